// File: rtl/rf_scoreboard.sv
// Register file with a per-entry pending (scoreboard) bit: one write port, one reserve port, two
// combinational read ports. Entry 0 is hardwired zero. Define RF_BYPASS_EN for write-to-read bypass.
module rf_scoreboard #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_a,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  output logic             busy1,
  output logic             busy2
);

  // Entry 0 has no storage; addresses outside 1..DEPTH-1 never match a decode line.
  logic [WIDTH-1:0] mem_q [1:DEPTH-1];
  logic [WIDTH-1:0] mem_d [1:DEPTH-1];
  logic [DEPTH-1:1] pend_q;
  logic [DEPTH-1:1] pend_d;
  logic [DEPTH-1:1] w_hit;
  logic [DEPTH-1:1] r_hit;

  always_comb begin
    w_hit = '0;
    r_hit = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_hit[i] = wen    && (wa    == AW'(i));
      r_hit[i] = rsv_en && (rsv_a == AW'(i));
    end
  end

  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (w_hit[i]) begin
        mem_d[i]  = wd;
        pend_d[i] = 1'b0;
      end
      // A same-edge reserve comes from a newer producer, so it overrides the clear.
      if (r_hit[i]) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  // NOTE: the data array is reset along with the pending bits because reads must return 0
  // immediately under reset; sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      mem_q  <= mem_d;
      pend_q <= pend_d;
    end
  end

`ifdef RF_BYPASS_EN
  logic w_any;
  assign w_any = |w_hit;
`endif

  // Returns {busy, data} for one read address.
  function automatic logic [WIDTH:0] read_port(input logic [AW-1:0] ra);
    logic [WIDTH:0] res;
    res = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (ra == AW'(i)) begin
        res = {pend_q[i], mem_q[i]};
      end
    end
`ifdef RF_BYPASS_EN
    // Reset wins over bypass so the outputs stay 0 while reset is held.
    if (rst_n && w_any && (wa == ra)) begin
      res = {1'b0, wd};
    end
`endif
    return res;
  endfunction

  always_comb begin
    {busy1, rd1} = read_port(ra1);
    {busy2, rd2} = read_port(ra2);
  end

endmodule

// File: tb/tb_rf_scoreboard.sv
// Scoreboard bench for rf_scoreboard: two instances (DEPTH=32 and DEPTH=20) share stimulus; a
// monitor pops hand-computed expectations and compares them against the selected read port.
module tb_rf_scoreboard;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wen = 1'b0;
  logic [AW-1:0] wa = '0;
  logic [W-1:0]  wd = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_a = '0;
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  logic [W-1:0]  a_rd1, a_rd2, b_rd1, b_rd2;
  logic          a_busy1, a_busy2, b_busy1, b_busy2;

  always #10 clk = ~clk;

  rf_scoreboard #(.WIDTH(W), .DEPTH(32), .AW(AW)) dut_a (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_a(rsv_a),
    .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2), .busy1(a_busy1), .busy2(a_busy2)
  );

  rf_scoreboard #(.WIDTH(W), .DEPTH(20), .AW(AW)) dut_b (
    .clk(clk), .rst_n(rst_n), .wen(wen), .wa(wa), .wd(wd), .rsv_en(rsv_en), .rsv_a(rsv_a),
    .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2), .busy1(b_busy1), .busy2(b_busy2)
  );

  typedef struct {
    string       name;
    bit          dut;   // 0: DEPTH=32, 1: DEPTH=20
    bit          port;  // 0: port 1, 1: port 2
    logic [W-1:0] rd;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  event sample_ev;

  // Monitor: compares every queued expectation against the live outputs.
  initial begin : monitor
    exp_t         e;
    logic [W-1:0] act_rd;
    logic         act_busy;
    forever begin
      @(sample_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case ({e.dut, e.port})
          2'b00:   begin act_rd = a_rd1; act_busy = a_busy1; end
          2'b01:   begin act_rd = a_rd2; act_busy = a_busy2; end
          2'b10:   begin act_rd = b_rd1; act_busy = b_busy1; end
          default: begin act_rd = b_rd2; act_busy = b_busy2; end
        endcase
        total++;
        if (act_rd !== e.rd || act_busy !== e.busy) begin
          bad++;
          $display("FAIL %s (dut%0d port%0d): got rd=%h busy=%b, want rd=%h busy=%b",
                   e.name, e.dut, e.port + 1, act_rd, act_busy, e.rd, e.busy);
        end
      end
    end
  end

  task automatic push(input string name, input bit dut, input bit port,
                      input logic [W-1:0] rd, input logic busy);
    exp_t e;
    e.name = name; e.dut = dut; e.port = port; e.rd = rd; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic push_both(input string name, input bit port, input logic [W-1:0] rd,
                           input logic busy);
    push(name, 1'b0, port, rd, busy);
    push(name, 1'b1, port, rd, busy);
  endtask

  task automatic sample();
    -> sample_ev;
    #2;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ra(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    ra1 = a1;
    ra2 = a2;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    wen = 1'b1; wa = a; wd = d;
    cycle();
    wen = 1'b0;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1; rsv_a = a;
    cycle();
    rsv_en = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    @(negedge clk);
    // Reset state.
    set_ra(5'd1, 5'd5);
    push_both("reset_state", 1'b0, '0, 1'b0);
    push_both("reset_state", 1'b1, '0, 1'b0);
    sample();
    @(negedge clk);
    rst_n = 1'b1;

    // Write / readback.
    wr(5'd7, 32'hDEADBEEF);
    set_ra(5'd7, 5'd31);
    push_both("wr7", 1'b0, 32'hDEADBEEF, 1'b0);
    push_both("e31_empty", 1'b1, '0, 1'b0);
    sample();
    wr(5'd31, 32'h12345678);
    push_both("wr7_hold", 1'b0, 32'hDEADBEEF, 1'b0);
    push(1'b0 ? "" : "wr31", 1'b0, 1'b1, 32'h12345678, 1'b0);
    push("oor_wr31", 1'b1, 1'b1, '0, 1'b0);
    sample();
    wr(5'd0, 32'hFFFFFFFF);
    set_ra(5'd0, 5'd0);
    push_both("wr0_ignored", 1'b0, '0, 1'b0);
    push_both("wr0_ignored", 1'b1, '0, 1'b0);
    sample();
    rsv(5'd0);
    push_both("rsv0_ignored", 1'b0, '0, 1'b0);
    sample();
    wr(5'd19, 32'h00001919);
    set_ra(5'd19, 5'd19);
    push_both("wr19", 1'b0, 32'h00001919, 1'b0);
    sample();

    // Scoreboard set / clear.
    rsv(5'd9);
    set_ra(5'd9, 5'd9);
    push_both("rsv9", 1'b0, '0, 1'b1);
    push_both("rsv9_same_port", 1'b1, '0, 1'b1);
    sample();
    wr(5'd9, 32'hA5A5A5A5);
    push_both("wr9_clears", 1'b0, 32'hA5A5A5A5, 1'b0);
    sample();
    rsv(5'd9);
    rsv(5'd9);
    push_both("double_rsv9", 1'b0, 32'hA5A5A5A5, 1'b1);
    sample();

    // Collision: write and reserve the same entry on one edge.
    wen = 1'b1; wa = 5'd9; wd = 32'h11;
    rsv_en = 1'b1; rsv_a = 5'd9;
    cycle();
    wen = 1'b0; rsv_en = 1'b0;
    push_both("collide9", 1'b0, 32'h11, 1'b1);
    sample();
    wr(5'd9, 32'h22);
    push_both("wr9_after_collide", 1'b0, 32'h22, 1'b0);
    sample();

    // Write and reserve to different addresses.
    wen = 1'b1; wa = 5'd3; wd = 32'h33;
    rsv_en = 1'b1; rsv_a = 5'd4;
    cycle();
    wen = 1'b0; rsv_en = 1'b0;
    set_ra(5'd3, 5'd4);
    push_both("diff_wr3", 1'b0, 32'h33, 1'b0);
    push_both("diff_rsv4", 1'b1, '0, 1'b1);
    sample();

    // Bypass window: entry 4 holds 0 and is pending while a write to it is presented.
    set_ra(5'd4, 5'd4);
    wen = 1'b1; wa = 5'd4; wd = 32'h55;
`ifdef RF_BYPASS_EN
    push_both("bypass4", 1'b0, 32'h55, 1'b0);
    push_both("bypass4", 1'b1, 32'h55, 1'b0);
`else
    push_both("no_bypass4", 1'b0, '0, 1'b1);
    push_both("no_bypass4", 1'b1, '0, 1'b1);
`endif
    sample();
    cycle();
    wen = 1'b0;
    push_both("post_wr4", 1'b0, 32'h55, 1'b0);
    push_both("post_wr4", 1'b1, 32'h55, 1'b0);
    sample();
    wr(5'd3, 32'h44);
    set_ra(5'd3, 5'd4);
    push_both("wr_nonpending3", 1'b0, 32'h44, 1'b0);
    sample();

    // Out of range for the DEPTH=20 instance.
    wr(5'd25, 32'h77);
    rsv(5'd25);
    set_ra(5'd25, 5'd19);
    push("e25_in_range", 1'b0, 1'b0, 32'h77, 1'b1);
    push("oor25", 1'b1, 1'b0, '0, 1'b0);
    push_both("e19_kept", 1'b1, 32'h00001919, 1'b0);
    sample();
    set_ra(5'd9, 5'd5);
    push_both("e9_no_alias", 1'b0, 32'h22, 1'b0);
    push_both("e5_no_alias", 1'b1, '0, 1'b0);
    sample();
    set_ra(5'd7, 5'd31);
    push_both("e7_kept", 1'b0, 32'hDEADBEEF, 1'b0);
    push("e31_kept", 1'b0, 1'b1, 32'h12345678, 1'b0);
    push("oor31_read", 1'b1, 1'b1, '0, 1'b0);
    sample();

    // Asynchronous reset mid-cycle with a write and reserve pending.
    wr(5'd1, 32'h0101);
    wr(5'd5, 32'h0505);
    rsv(5'd31);
    set_ra(5'd1, 5'd5);
    push_both("pre_rst1", 1'b0, 32'h0101, 1'b0);
    push_both("pre_rst5", 1'b1, 32'h0505, 1'b0);
    sample();
    wen = 1'b1; wa = 5'd5; wd = 32'hBAD;
    rsv_en = 1'b1; rsv_a = 5'd1;
    #2;
    rst_n = 1'b0;
    push_both("async_rst1", 1'b0, '0, 1'b0);
    push_both("async_rst5", 1'b1, '0, 1'b0);
    sample();
    set_ra(5'd31, 5'd7);
    push_both("async_rst31", 1'b0, '0, 1'b0);
    push_both("async_rst7", 1'b1, '0, 1'b0);
    sample();
    cycle();
    set_ra(5'd1, 5'd5);
    push_both("rst_override1", 1'b0, '0, 1'b0);
    push_both("rst_override5", 1'b1, '0, 1'b0);
    sample();
    wen = 1'b0; rsv_en = 1'b0;
    rst_n = 1'b1;
    wr(5'd5, 32'hAB);
    push_both("first_edge_wr5", 1'b1, 32'hAB, 1'b0);
    push_both("first_edge_e1", 1'b0, '0, 1'b0);
    sample();

    #5;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
